gprs_banked: RTL

Parametrised successor general-purpose register file for the dual-core RISC-V design. It holds NUM_HARTS independent banks of NREGS x XLEN registers, with register 0 hardwired to zero in every bank. It provides two combinational read ports, one synchronous write port and a per-register pending-write scoreboard. A per-bank soft-clear sequencer zeroes one bank without a global reset. It sits between decode/issue (reads, scoreboard set) and writeback (writes) of both cores.

---
 rtl/gprs_banked.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/gprs_banked.sv
// Banked GPR file: NUM_HARTS banks of NREGS x XLEN, x0 hardwired to zero,
// two combinational read ports, one write port, per-register pending
// scoreboard and a per-bank soft-clear sweep sequencer.
// Ports: clk, rst (async, active-high); read: rd_hart, ra/rb_addr ->
// ra/rb_data, ra/rb_busy; write: wr_en, wr_hart, wr_addr, wr_data;
// scoreboard: sb_set, sb_hart, sb_addr; clear: clr_req, clr_hart -> clr_busy.
// Optional macro GPRS_BANKED_BYPASS_EN forwards same-cycle writes to reads.
module gprs_banked #(
    parameter int XLEN      = 32,
    parameter int NREGS     = 32,
    parameter int NUM_HARTS = 2,
    parameter int ADDR_W    = $clog2(NREGS),
    parameter int HART_W    = (NUM_HARTS > 1 ? $clog2(NUM_HARTS) : 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [HART_W-1:0] rd_hart,
    input  logic [ADDR_W-1:0] ra_addr,
    input  logic [ADDR_W-1:0] rb_addr,
    output logic [XLEN-1:0]   ra_data,
    output logic [XLEN-1:0]   rb_data,
    output logic              ra_busy,
    output logic              rb_busy,
    input  logic              wr_en,
    input  logic [HART_W-1:0] wr_hart,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [XLEN-1:0]   wr_data,
    input  logic              sb_set,
    input  logic [HART_W-1:0] sb_hart,
    input  logic [ADDR_W-1:0] sb_addr,
    input  logic              clr_req,
    input  logic [HART_W-1:0] clr_hart,
    output logic              clr_busy
);

    typedef enum logic {
        IDLE,
        SWEEP
    } state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NREGS - 1);

    logic [XLEN-1:0]  regs [NUM_HARTS][NREGS];
    logic [NREGS-1:0] sb   [NUM_HARTS];

    state_t            state;
    logic [HART_W-1:0] tgt;
    logic [ADDR_W-1:0] idx;

    function automatic logic hart_ok(input logic [HART_W-1:0] h);
        return 32'(h) < 32'(NUM_HARTS);
    endfunction

    logic sweeping;
    logic we_ok;
    logic set_ok;

    assign sweeping = (state == SWEEP);

    // Traffic aimed at the bank being swept is dropped for the whole sweep.
    assign we_ok = wr_en && (wr_addr != '0) && hart_ok(wr_hart)
                 && !(sweeping && wr_hart == tgt);
    assign set_ok = sb_set && (sb_addr != '0) && hart_ok(sb_hart)
                  && !(sweeping && sb_hart == tgt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                sb[h] <= '0;
                for (int r = 0; r < NREGS; r++) begin
                    regs[h][r] <= '0;
                end
            end
        end else begin
            if (we_ok) begin
                regs[wr_hart][wr_addr] <= wr_data;
                sb[wr_hart][wr_addr]   <= 1'b0;
            end
            // Placed after the write so a same-target set wins.
            if (set_ok) begin
                sb[sb_hart][sb_addr] <= 1'b1;
            end
            if (sweeping) begin
                regs[tgt][idx] <= '0;
                sb[tgt][idx]   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            tgt      <= '0;
            idx      <= '0;
            clr_busy <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (clr_req && hart_ok(clr_hart)) begin
                        state    <= SWEEP;
                        tgt      <= clr_hart;
                        idx      <= ADDR_W'(1);
                        clr_busy <= 1'b1;
                    end
                end
                SWEEP: begin
                    if (idx == LAST) begin
                        state    <= IDLE;
                        clr_busy <= 1'b0;
                    end else begin
                        idx <= idx + ADDR_W'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    clr_busy <= 1'b0;
                end
            endcase
        end
    end

    logic fwd_a;
    logic fwd_b;

`ifdef GPRS_BANKED_BYPASS_EN
    assign fwd_a = we_ok && (wr_hart == rd_hart) && (wr_addr == ra_addr);
    assign fwd_b = we_ok && (wr_hart == rd_hart) && (wr_addr == rb_addr);
`else
    assign fwd_a = 1'b0;
    assign fwd_b = 1'b0;
`endif

    always_comb begin
        ra_data = '0;
        rb_data = '0;
        ra_busy = 1'b0;
        rb_busy = 1'b0;
        if (hart_ok(rd_hart)) begin
            if (fwd_a) begin
                ra_data = wr_data;
            end else if (ra_addr != '0) begin
                ra_data = regs[rd_hart][ra_addr];
                ra_busy = sb[rd_hart][ra_addr];
            end
            if (fwd_b) begin
                rb_data = wr_data;
            end else if (rb_addr != '0) begin
                rb_data = regs[rd_hart][rb_addr];
                rb_busy = sb[rd_hart][rb_addr];
            end
        end
    end

endmodule
